ysyx_22040175_mem_arbiter: RTL and testbench

//  Shares one 64-bit memory bus between the IF stage (instruction fetch, read-only) and the MEM stage
//  (load/store). Sequences each access as grant -> bus request -> bus response and returns data to its owner.

---
 rtl/ysyx_22040175_mem_arbiter_if.sv | 56 +++++
 rtl/ysyx_22040175_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22040175_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040175_mem_arbiter_if.sv
// Handshake bundle between the IF/MEM requesters, the shared memory bus and the arbiter.
// Ports: IF request/response/flush, MEM request/response, bus request/response, pipeline stalls.
// Modports: slave = arbiter view, master = pipeline + memory-model view.
interface ysyx_22040175_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // IF side
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_resp_valid;
  logic [31:0]       if_resp_data;
  // MEM side
  logic              mem_req_valid;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  // memory bus
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_req_wen;
  logic [DATA_W-1:0] bus_req_wdata;
  logic [7:0]        bus_req_wmask;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_data;
  // pipeline holds
  logic              if_stall;
  logic              mem_stall;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
    input  bus_req_ready, bus_resp_valid, bus_resp_data,
    output if_stall, mem_stall
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
    output bus_req_ready, bus_resp_valid, bus_resp_data,
    input  if_stall, mem_stall
  );
endinterface

// File: rtl/ysyx_22040175_mem_arbiter.sv
// Purpose: shares one 64-bit memory bus between IF (fetch) and MEM (load/store), one access in flight.
// Latency: accept T, bus_req_valid T+1, response pulse one cycle after bus_resp_valid (min T+3).
// Backpressure: requesters held via *_req_ready/*_stall; bus_req_valid held until bus_req_ready.
// Ports: clk, rst_n (async, active low) and the slave modport of ysyx_22040175_mem_arbiter_if.
module ysyx_22040175_mem_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MEM_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_22040175_mem_arbiter_if.slave io
);

  localparam int STREAK_W = $clog2(MEM_STREAK_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUS_REQ  = 2'd1,
    S_BUS_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_own_if;      // 1: IF owns the current access, 0: MEM
  logic                r_drop;        // IF response discarded by a flush
  logic                r_if_busy;
  logic                r_mem_busy;
  logic [STREAK_W-1:0] r_streak;

  logic                r_bus_valid;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic                r_bus_wen;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [7:0]          r_bus_wmask;

  logic                r_if_resp_valid;
  logic [31:0]         r_if_resp_data;
  logic                r_mem_resp_valid;
  logic [DATA_W-1:0]   r_mem_resp_data;

  logic                w_idle;
  logic                w_if_pri;
  logic                w_grant_if;
  logic                w_grant_mem;
  logic                w_if_suppress;

  assign w_idle   = (r_state == S_IDLE);
  // IF is forced through once MEM has taken MEM_STREAK_MAX grants in a row while IF waited.
  assign w_if_pri = (r_streak == STREAK_W'(MEM_STREAK_MAX));

  // Readies are combinational; gating with rst_n keeps every output low while reset is held.
  assign w_grant_mem = rst_n & w_idle & io.mem_req_valid & ~(io.if_req_valid & w_if_pri);
  assign w_grant_if  = rst_n & w_idle & io.if_req_valid & ~w_grant_mem;

  // A flush arriving together with the bus response still kills the fetch.
  assign w_if_suppress = r_drop | io.if_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_own_if         <= 1'b0;
      r_drop           <= 1'b0;
      r_if_busy        <= 1'b0;
      r_mem_busy       <= 1'b0;
      r_streak         <= '0;
      r_bus_valid      <= 1'b0;
      r_bus_addr       <= '0;
      r_bus_wen        <= 1'b0;
      r_bus_wdata      <= '0;
      r_bus_wmask      <= '0;
      r_if_resp_valid  <= 1'b0;
      r_if_resp_data   <= '0;
      r_mem_resp_valid <= 1'b0;
      r_mem_resp_data  <= '0;
    end else begin
      r_if_resp_valid  <= 1'b0;
      r_mem_resp_valid <= 1'b0;

      // Streak counts MEM grants taken while IF was left waiting.
      if (!io.if_req_valid || w_grant_if) begin
        r_streak <= '0;
      end else if (w_grant_mem && !w_if_pri) begin
        r_streak <= r_streak + STREAK_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_if || w_grant_mem) begin
            r_state     <= S_BUS_REQ;
            r_bus_valid <= 1'b1;
            r_own_if    <= w_grant_if;
            r_drop      <= 1'b0;
            r_if_busy   <= w_grant_if;
            r_mem_busy  <= w_grant_mem;
            if (w_grant_if) begin
              r_bus_addr  <= io.if_req_addr;
              r_bus_wen   <= 1'b0;
              r_bus_wdata <= '0;
              r_bus_wmask <= '0;
            end else begin
              r_bus_addr  <= io.mem_req_addr;
              r_bus_wen   <= io.mem_req_wen;
              r_bus_wdata <= io.mem_req_wdata;
              r_bus_wmask <= io.mem_req_wmask;
            end
          end
        end

        S_BUS_REQ: begin
          if (r_own_if && io.if_flush) begin
            r_drop <= 1'b1;
          end
          if (io.bus_req_ready) begin
            r_bus_valid <= 1'b0;
            r_state     <= S_BUS_RESP;
          end
        end

        S_BUS_RESP: begin
          if (r_own_if && io.if_flush) begin
            r_drop <= 1'b1;
          end
          if (io.bus_resp_valid) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            if (r_own_if) begin
              r_if_busy <= 1'b0;
              if (!w_if_suppress) begin
                r_if_resp_valid <= 1'b1;
                // Bit 2 of the fetch address picks the instruction word in the doubleword.
                r_if_resp_data  <= r_bus_addr[2] ? io.bus_resp_data[63:32]
                                                 : io.bus_resp_data[31:0];
              end
            end else begin
              r_mem_busy       <= 1'b0;
              r_mem_resp_valid <= 1'b1;
              r_mem_resp_data  <= io.bus_resp_data;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io.if_req_ready   = w_grant_if;
  assign io.mem_req_ready  = w_grant_mem;
  assign io.if_resp_valid  = r_if_resp_valid;
  assign io.if_resp_data   = r_if_resp_data;
  assign io.mem_resp_valid = r_mem_resp_valid;
  assign io.mem_resp_data  = r_mem_resp_data;
  assign io.bus_req_valid  = r_bus_valid;
  assign io.bus_req_addr   = r_bus_addr;
  assign io.bus_req_wen    = r_bus_wen;
  assign io.bus_req_wdata  = r_bus_wdata;
  assign io.bus_req_wmask  = r_bus_wmask;
  assign io.if_stall       = rst_n & ((io.if_req_valid & ~w_grant_if) | r_if_busy);
  assign io.mem_stall      = rst_n & ((io.mem_req_valid & ~w_grant_mem) | r_mem_busy);

endmodule

// File: tb/tb_ysyx_22040175_mem_arbiter.sv
module tb_ysyx_22040175_mem_arbiter;
  localparam int STREAK_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22040175_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bif ();

  ysyx_22040175_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bif.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy, m_issued, m_own_if, m_drop;
  logic [63:0] m_addr, m_wdata;
  bit          m_wen;
  logic [7:0]  m_wmask;
  bit          m_pulse_if, m_pulse_mem;
  logic [31:0] m_if_data;
  logic [63:0] m_mem_data;
  int          m_streak;
  bit          m_if_taken, m_mem_taken;
  logic [1:0]  m_g, c_g;

  // Who gets the bus this cycle: {if, mem}
  function automatic logic [1:0] pick(input bit busy, input int streak, input bit ifv, input bit memv);
    if (busy) return 2'b00;
    if (memv && !(ifv && streak == STREAK_MAX)) return 2'b01;
    if (ifv) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_issued = 0; m_own_if = 0; m_drop = 0;
      m_pulse_if = 0; m_pulse_mem = 0; m_streak = 0;
      m_if_taken = 0; m_mem_taken = 0;
    end else begin
      m_g = pick(m_busy, m_streak, bif.if_req_valid, bif.mem_req_valid);
      m_if_taken  = m_g[1];
      m_mem_taken = m_g[0];
      m_pulse_if  = 0;
      m_pulse_mem = 0;
      if (m_busy) begin
        if (m_own_if && bif.if_flush) m_drop = 1;
        if (!m_issued) begin
          if (bif.bus_req_ready) m_issued = 1;
        end else if (bif.bus_resp_valid) begin
          m_busy = 0;
          if (m_own_if) begin
            m_pulse_if = !m_drop;
            m_if_data  = m_addr[2] ? bif.bus_resp_data[63:32] : bif.bus_resp_data[31:0];
          end else begin
            m_pulse_mem = 1;
            m_mem_data  = bif.bus_resp_data;
          end
        end
      end else if (m_g != 2'b00) begin
        m_busy = 1; m_issued = 0; m_drop = 0; m_own_if = m_g[1];
        if (m_g[1]) begin
          m_addr = bif.if_req_addr; m_wen = 0; m_wdata = 0; m_wmask = 0;
        end else begin
          m_addr = bif.mem_req_addr; m_wen = bif.mem_req_wen;
          m_wdata = bif.mem_req_wdata; m_wmask = bif.mem_req_wmask;
        end
      end
      if (!bif.if_req_valid || m_g[1]) m_streak = 0;
      else if (m_g[0] && m_streak < STREAK_MAX) m_streak++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_if_req_ready", bif.if_req_ready, 0);
      chk("rst_mem_req_ready", bif.mem_req_ready, 0);
      chk("rst_bus_req_valid", bif.bus_req_valid, 0);
      chk("rst_bus_req_addr", bif.bus_req_addr, 0);
      chk("rst_bus_req_wen", bif.bus_req_wen, 0);
      chk("rst_bus_req_wdata", bif.bus_req_wdata, 0);
      chk("rst_bus_req_wmask", bif.bus_req_wmask, 0);
      chk("rst_if_resp_valid", bif.if_resp_valid, 0);
      chk("rst_if_resp_data", bif.if_resp_data, 0);
      chk("rst_mem_resp_valid", bif.mem_resp_valid, 0);
      chk("rst_mem_resp_data", bif.mem_resp_data, 0);
      chk("rst_if_stall", bif.if_stall, 0);
      chk("rst_mem_stall", bif.mem_stall, 0);
    end else begin
      c_g = pick(m_busy, m_streak, bif.if_req_valid, bif.mem_req_valid);
      chk("if_req_ready", bif.if_req_ready, c_g[1]);
      chk("mem_req_ready", bif.mem_req_ready, c_g[0]);
      chk("bus_req_valid", bif.bus_req_valid, m_busy && !m_issued);
      if (m_busy && !m_issued) begin
        chk("bus_req_addr", bif.bus_req_addr, m_addr);
        chk("bus_req_wen", bif.bus_req_wen, m_wen);
        chk("bus_req_wdata", bif.bus_req_wdata, m_wdata);
        chk("bus_req_wmask", bif.bus_req_wmask, m_wmask);
      end
      chk("if_resp_valid", bif.if_resp_valid, m_pulse_if);
      if (m_pulse_if) chk("if_resp_data", bif.if_resp_data, m_if_data);
      chk("mem_resp_valid", bif.mem_resp_valid, m_pulse_mem);
      if (m_pulse_mem) chk("mem_resp_data", bif.mem_resp_data, m_mem_data);
      chk("if_stall", bif.if_stall, (bif.if_req_valid && !c_g[1]) || (m_busy && m_own_if));
      chk("mem_stall", bif.mem_stall, (bif.mem_req_valid && !c_g[0]) || (m_busy && !m_own_if));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bif.bus_req_ready  = 1;
    bif.bus_resp_valid = 1;
    repeat (4) tick();
    bif.bus_resp_valid = 0;
  endtask

  initial begin
    int  mem_cnt;
    bit  if_got;
    bif.if_req_valid = 0; bif.if_req_addr = 0; bif.if_flush = 0;
    bif.mem_req_valid = 0; bif.mem_req_wen = 0; bif.mem_req_addr = 0;
    bif.mem_req_wdata = 0; bif.mem_req_wmask = 0;
    bif.bus_req_ready = 0; bif.bus_resp_valid = 0; bif.bus_resp_data = 0;
    repeat (3) tick();
    chk("reset_bus_req_valid", bif.bus_req_valid, 0);
    rst_n = 1;
    tick();

    // 1: IF alone, minimum latency, upper word selected
    bif.if_req_valid = 1; bif.if_req_addr = 64'h8000_0004; bif.bus_req_ready = 1; #1;
    chk("t1_accept", bif.if_req_ready, 1);
    tick(); bif.if_req_valid = 0;
    chk("t1_bus_req_valid", bif.bus_req_valid, 1);
    tick(); bif.bus_resp_valid = 1; bif.bus_resp_data = 64'h1111_2222_3333_4444;
    tick(); bif.bus_resp_valid = 0;
    chk("t1_if_resp_valid", bif.if_resp_valid, 1);
    chk("t1_if_resp_data", bif.if_resp_data, 32'h1111_2222);
    tick();
    chk("t1_pulse_single", bif.if_resp_valid, 0);

    // 2: both valid -> MEM first, IF next
    bif.bus_req_ready = 1; bif.bus_resp_valid = 1; bif.bus_resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    bif.if_req_valid = 1; bif.if_req_addr = 64'h8000_0010;
    bif.mem_req_valid = 1; bif.mem_req_wen = 0; bif.mem_req_addr = 64'h8000_1000; #1;
    chk("t2_mem_first", bif.mem_req_ready, 1);
    chk("t2_if_waits", bif.if_req_ready, 0);
    chk("t2_if_stall_wait", bif.if_stall, 1);
    tick(); bif.mem_req_valid = 0;
    chk("t2_mem_stall_busy", bif.mem_stall, 1);
    tick(); tick();
    chk("t2_mem_resp", bif.mem_resp_valid, 1);
    chk("t2_mem_stall_low", bif.mem_stall, 0);
    chk("t2_if_granted", bif.if_req_ready, 1);
    chk("t2_if_stall_low", bif.if_stall, 0);
    tick(); bif.if_req_valid = 0;
    tick(); tick();
    chk("t2_if_resp_valid", bif.if_resp_valid, 1);
    chk("t2_if_resp_data", bif.if_resp_data, 32'hCCCC_DDDD);

    // 3: MEM continuous, IF waiting -> 4 MEM grants then IF
    bif.mem_req_valid = 1; bif.if_req_valid = 1; bif.if_req_addr = 64'h8000_0040; #1;
    mem_cnt = 0; if_got = 0;
    for (int i = 0; i < 40 && !if_got; i++) begin
      if (bif.if_req_ready) if_got = 1;
      else if (bif.mem_req_ready) mem_cnt++;
      tick();
    end
    chk("t3_if_forced", if_got, 1);
    chk("t3_mem_grants", mem_cnt, 4);
    bif.if_req_valid = 0; bif.mem_req_valid = 0;
    drain();

    // 4: flush while IF waits for response
    bif.bus_resp_valid = 0; bif.bus_req_ready = 1;
    bif.if_req_valid = 1; bif.if_req_addr = 64'h8000_0020; #1;
    chk("t4_accept", bif.if_req_ready, 1);
    tick(); bif.if_req_valid = 0;
    tick(); bif.if_flush = 1;
    tick(); bif.if_flush = 0; bif.bus_resp_valid = 1;
    tick(); bif.bus_resp_valid = 0;
    chk("t4_no_if_resp", bif.if_resp_valid, 0);
    chk("t4_if_stall_low", bif.if_stall, 0);
    bif.mem_req_valid = 1; bif.mem_req_addr = 64'h8000_3000; #1;
    chk("t4_next_grant", bif.mem_req_ready, 1);
    tick(); bif.mem_req_valid = 0;
    drain();

    // 5: store with bus backpressure
    bif.bus_req_ready = 0; bif.bus_resp_valid = 0;
    bif.mem_req_valid = 1; bif.mem_req_wen = 1; bif.mem_req_addr = 64'h8000_2008;
    bif.mem_req_wdata = 64'hDEAD_BEEF_0123_4567; bif.mem_req_wmask = 8'h0F; #1;
    chk("t5_accept", bif.mem_req_ready, 1);
    tick();
    bif.mem_req_valid = 0; bif.mem_req_wen = 0; bif.mem_req_wdata = 0; bif.mem_req_wmask = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_valid_held", bif.bus_req_valid, 1);
      chk("t5_wmask", bif.bus_req_wmask, 8'h0F);
      chk("t5_wdata", bif.bus_req_wdata, 64'hDEAD_BEEF_0123_4567);
      chk("t5_wen", bif.bus_req_wen, 1);
      tick();
    end
    bif.bus_req_ready = 1;
    tick(); bif.bus_resp_valid = 1;
    tick(); bif.bus_resp_valid = 0;
    chk("t5_store_ack", bif.mem_resp_valid, 1);
    chk("t5_mem_stall_low", bif.mem_stall, 0);
    tick();

    // 6: async reset during BUS_REQ
    bif.bus_req_ready = 0;
    bif.if_req_valid = 1; bif.if_req_addr = 64'h8000_0030; #1;
    chk("t6_accept", bif.if_req_ready, 1);
    tick();
    chk("t6_in_bus_req", bif.bus_req_valid, 1);
    rst_n = 0; #1;
    chk("t6_rst_bus_req_valid", bif.bus_req_valid, 0);
    chk("t6_rst_bus_req_addr", bif.bus_req_addr, 0);
    chk("t6_rst_if_stall", bif.if_stall, 0);
    chk("t6_rst_if_req_ready", bif.if_req_ready, 0);
    bif.if_req_valid = 0; bif.bus_resp_valid = 1;
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    chk("t6_stray_resp_ignored", bif.if_resp_valid, 0);
    chk("t6_idle_after_reset", bif.bus_req_valid, 0);
    bif.bus_resp_valid = 0; bif.bus_req_ready = 1;
    bif.if_req_valid = 1; bif.if_req_addr = 64'h8000_0000; #1;
    chk("t6_restart_accept", bif.if_req_ready, 1);
    tick(); bif.if_req_valid = 0;
    tick(); bif.bus_resp_valid = 1; bif.bus_resp_data = 64'h5555_6666_7777_8888;
    tick(); bif.bus_resp_valid = 0;
    chk("t6_restart_data", bif.if_resp_data, 32'h7777_8888);
    chk("t6_restart_valid", bif.if_resp_valid, 1);
    tick();

    // Random traffic checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      if (!bif.if_req_valid || m_if_taken) begin
        bif.if_req_valid = ($urandom_range(0, 99) < 60);
        bif.if_req_addr  = {$urandom, $urandom};
      end
      if (!bif.mem_req_valid || m_mem_taken) begin
        bif.mem_req_valid = ($urandom_range(0, 99) < 60);
        bif.mem_req_wen   = $urandom_range(0, 1);
        bif.mem_req_addr  = {$urandom, $urandom};
        bif.mem_req_wdata = {$urandom, $urandom};
        bif.mem_req_wmask = 8'($urandom);
      end
      bif.bus_req_ready  = $urandom_range(0, 1);
      bif.bus_resp_valid = ($urandom_range(0, 99) < 40);
      bif.bus_resp_data  = {$urandom, $urandom};
      bif.if_flush       = ($urandom_range(0, 99) < 8);
      if (c == 1500) begin
        #2 rst_n = 0;
        tick(); tick();
        rst_n = 1;
      end
      tick();
    end
    bif.if_req_valid = 0; bif.mem_req_valid = 0; bif.if_flush = 0;
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
